// File: rtl/rr_index_arbiter_if.sv
// Grant handshake between rr_index_arbiter and its consumer.
// Carries the request vector, valid/ready, and the winning index.
interface rr_index_arbiter_if #(
    parameter int width = 8
);
    localparam int idxw = $clog2(width);

    logic [width-1:0] Req;
    logic             Valid;
    logic             Ready;
    logic [idxw-1:0]  Idx;

    modport master (
        input  Req,
        input  Ready,
        output Valid,
        output Idx
    );

    modport slave (
        output Req,
        output Ready,
        input  Valid,
        input  Idx
    );
endinterface

// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter emitting a binary winner index.
// Each grant is held under valid/ready until the consumer accepts it.
module rr_index_arbiter #(
    parameter int width = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    rr_index_arbiter_if.master arb
);
    localparam int idxw = $clog2(width);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t          state;
    logic            valid_q;
    logic [idxw-1:0] idx_q;
    logic [idxw-1:0] ptr_q;
    logic [idxw-1:0] nxt_ptr;
    logic [idxw-1:0] base;
    logic [idxw-1:0] cand;
    logic [idxw-1:0] hit_idx;
    logic            hit;
    logic            accept;

    assign accept  = valid_q & arb.Ready;
    assign nxt_ptr = (idx_q == idxw'(width - 1)) ? '0 : idx_q + idxw'(1);
    // On accept the search already uses the advanced pointer.
    assign base    = accept ? nxt_ptr : ptr_q;

    // Walk downward so the lowest offset from base wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        cand    = '0;
        for (int k = width - 1; k >= 0; k--) begin
            int j;
            j = int'(base) + k;
            if (j >= width) begin
                j = j - width;
            end
            cand = idxw'(j);
            if (arb.Req[cand]) begin
                hit     = 1'b1;
                hit_idx = cand;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (hit) begin
                        idx_q   <= hit_idx;
                        valid_q <= 1'b1;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (arb.Ready) begin
                        ptr_q <= nxt_ptr;
                        if (hit) begin
                            idx_q <= hit_idx;
                        end else begin
                            valid_q <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign arb.Valid = valid_q;
    assign arb.Idx   = idx_q;
endmodule

// File: tb/tb_rr_index_arbiter.sv
// Directed bench for rr_index_arbiter at width 8 and width 5.
// Each task drives one scenario and checks hand-computed grants.
module tb_rr_index_arbiter;
    logic clk;
    logic rst_ni;
    int   total;
    int   bad;

    rr_index_arbiter_if #(.width(8)) a8 ();
    rr_index_arbiter_if #(.width(5)) a5 ();

    rr_index_arbiter #(.width(8)) u8 (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .arb    (a8.master)
    );

    rr_index_arbiter #(.width(5)) u5 (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .arb    (a5.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_ni   = 1'b0;
        a8.Req   = '0;
        a8.Ready = 1'b0;
        a5.Req   = '0;
        a5.Ready = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset;
        rst_ni   = 1'b0;
        a8.Req   = '0;
        a8.Ready = 1'b1;
        tick();
        tick();
        total++;
        if ({a8.Valid, a8.Idx} !== 4'b0_000) begin
            bad++;
            $display("FAIL reset_in: valid=%b idx=%0d want 0/0",
                     a8.Valid, a8.Idx);
        end
        rst_ni = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if ({a8.Valid, a8.Idx} !== 4'b0_000) begin
                bad++;
                $display("FAIL reset_idle c%0d: valid=%b idx=%0d want 0/0",
                         i, a8.Valid, a8.Idx);
            end
        end
    endtask

    task automatic test_all_req;
        do_reset();
        a8.Req   = 8'hFF;
        a8.Ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (a8.Valid !== 1'b1 || a8.Idx !== 3'(i % 8)) begin
                bad++;
                $display("FAIL all_req c%0d: valid=%b idx=%0d want 1/%0d",
                         i, a8.Valid, a8.Idx, i % 8);
            end
        end
        a8.Req = '0;
        tick();
        total++;
        if (a8.Valid !== 1'b0 || a8.Idx !== 3'd1) begin
            bad++;
            $display("FAIL all_req_drain: valid=%b idx=%0d want 0/1",
                     a8.Valid, a8.Idx);
        end
    endtask

    task automatic test_two_req;
        do_reset();
        a8.Req   = 8'h81;
        a8.Ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (a8.Valid !== 1'b1 || a8.Idx !== ((i % 2 == 1) ? 3'd7 : 3'd0)) begin
                bad++;
                $display("FAIL two_req c%0d: valid=%b idx=%0d want 1/%0d",
                         i, a8.Valid, a8.Idx, (i % 2 == 1) ? 7 : 0);
            end
        end
        a8.Req = 8'h80;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (a8.Valid !== 1'b1 || a8.Idx !== 3'd7) begin
                bad++;
                $display("FAIL alone_regrant c%0d: valid=%b idx=%0d want 1/7",
                         i, a8.Valid, a8.Idx);
            end
        end
    endtask

    task automatic test_hold;
        do_reset();
        a8.Req   = 8'h0C;
        a8.Ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (a8.Valid !== 1'b1 || a8.Idx !== 3'd2) begin
                bad++;
                $display("FAIL hold c%0d: valid=%b idx=%0d want 1/2",
                         i, a8.Valid, a8.Idx);
            end
            if (i == 2) a8.Req = 8'h08;
        end
        a8.Ready = 1'b1;
        tick();
        total++;
        if (a8.Valid !== 1'b1 || a8.Idx !== 3'd3) begin
            bad++;
            $display("FAIL hold_next: valid=%b idx=%0d want 1/3",
                     a8.Valid, a8.Idx);
        end
        a8.Req = '0;
        tick();
        total++;
        if (a8.Valid !== 1'b0 || a8.Idx !== 3'd3) begin
            bad++;
            $display("FAIL hold_drain: valid=%b idx=%0d want 0/3",
                     a8.Valid, a8.Idx);
        end
        tick();
        total++;
        if (a8.Valid !== 1'b0 || a8.Idx !== 3'd3) begin
            bad++;
            $display("FAIL ready_idle: valid=%b idx=%0d want 0/3",
                     a8.Valid, a8.Idx);
        end
        a8.Req = 8'h11;
        tick();
        total++;
        if (a8.Valid !== 1'b1 || a8.Idx !== 3'd4) begin
            bad++;
            $display("FAIL ptr_kept: valid=%b idx=%0d want 1/4",
                     a8.Valid, a8.Idx);
        end
    endtask

    task automatic test_wrap5;
        do_reset();
        a5.Req   = 5'b10001;
        a5.Ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (a5.Valid !== 1'b1 || a5.Idx !== ((i % 2 == 1) ? 3'd4 : 3'd0)) begin
                bad++;
                $display("FAIL wrap5_pair c%0d: valid=%b idx=%0d want 1/%0d",
                         i, a5.Valid, a5.Idx, (i % 2 == 1) ? 4 : 0);
            end
        end
        do_reset();
        a5.Req   = 5'b11111;
        a5.Ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            total++;
            if (a5.Valid !== 1'b1 || a5.Idx !== 3'(i % 5)) begin
                bad++;
                $display("FAIL wrap5_all c%0d: valid=%b idx=%0d want 1/%0d",
                         i, a5.Valid, a5.Idx, i % 5);
            end
        end
        a5.Req = '0;
        tick();
    endtask

    task automatic test_reset_mid_hold;
        do_reset();
        a8.Req   = 8'h20;
        a8.Ready = 1'b0;
        tick();
        total++;
        if (a8.Valid !== 1'b1 || a8.Idx !== 3'd5) begin
            bad++;
            $display("FAIL pre_rst_hold: valid=%b idx=%0d want 1/5",
                     a8.Valid, a8.Idx);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        total++;
        if (a8.Valid !== 1'b0 || a8.Idx !== 3'd0) begin
            bad++;
            $display("FAIL async_rst: valid=%b idx=%0d want 0/0",
                     a8.Valid, a8.Idx);
        end
        a8.Req   = 8'hFF;
        a8.Ready = 1'b1;
        tick();
        rst_ni = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (a8.Valid !== 1'b1 || a8.Idx !== 3'(i)) begin
                bad++;
                $display("FAIL post_rst c%0d: valid=%b idx=%0d want 1/%0d",
                         i, a8.Valid, a8.Idx, i);
            end
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_ni   = 1'b0;
        a8.Req   = '0;
        a8.Ready = 1'b0;
        a5.Req   = '0;
        a5.Ready = 1'b0;
        test_reset();
        test_all_req();
        test_two_req();
        test_hold();
        test_wrap5();
        test_reset_mid_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, bad=%0d", bad);
        $fatal(1);
    end
endmodule
